mux_2_rr_arbiter: RTL and testbench
===================================

Name: mux_2_rr_arbiter

Overview:
- Round-robin arbiter that shares one N-bit output channel between two valid/ready requesters.
- The 2:1 data selection is done by one mux_2 instance whose select is the arbitration grant; the selected word is captured in a 1-entry output register.
- Sits between two producer stages and one shared consumer, such as a shared bus or functional-unit port.
- Full throughput: one transfer per cycle when the consumer is always ready.

Parameters:
- N, 64, data width of each requester and of the output.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_data0  input  N  requester 0 data.
- i_valid0  input  1  requester 0 has data.
- o_ready0  output  1  requester 0 word accepted this cycle.
- i_data1  input  N  requester 1 data.
- i_valid1  input  1  requester 1 has data.
- o_ready1  output  1  requester 1 word accepted this cycle.
- o_data  output  N  registered output word.
- o_valid  output  1  o_data holds a valid word.
- i_ready  input  1  consumer accepts o_data this cycle.
- o_sel  output  1  source requester (0/1) of the word currently in o_data.

Behaviour:
- State registers: out_valid, out_data[N-1:0], out_sel, prio.
  - prio=0 means requester 0 wins a tie; prio=1 means requester 1 wins.
  - o_valid=out_valid, o_data=out_data, o_sel=out_sel.
- Reset, when i_rst_n=0 at a rising edge: out_valid=0, out_data=0, out_sel=0, prio=0.
  - o_ready0 and o_ready1 are forced to 0 combinationally while i_rst_n=0.
  - Reset mid-transfer discards the held word; no handshake completes in that cycle.
- can_accept = !out_valid || i_ready. The output register is empty, or is being drained this cycle.
- Grant g, combinational, only meaningful when can_accept:
  - both valid: g=prio.
  - only i_valid0: g=0.
  - only i_valid1: g=1.
  - neither valid: no grant.
- Ready outputs:
  - o_ready0 = i_rst_n && can_accept && i_valid0 && (g==0).
  - o_ready1 = i_rst_n && can_accept && i_valid1 && (g==1).
  - Ready depends combinationally on valid and on i_ready. At most one ready is high per cycle.
- Accept event, when o_readyX=1 at an edge:
  - out_data <= mux_2 output with i_s=g.
  - out_sel <= g, out_valid <= 1, prio <= ~g.
- Drain without refill (out_valid && i_ready, no accept): out_valid <= 0; out_data and out_sel hold their values.
- Stall (out_valid && !i_ready):
  - All registers hold; o_ready0=o_ready1=0.
  - o_data stays stable until consumed.
- Latency: a word accepted at edge k appears on o_data/o_valid right after edge k, i.e. in cycle k+1.
- Simultaneous drain and accept in one cycle: the old word is consumed and the new word is loaded, with no bubble.
- Fairness:
  - prio toggles on every accept, including uncontended ones.
  - Under continuous contention, grants alternate 0,1,0,1...
  - Neither requester waits more than one transfer while the other is granted.
- Requesters must hold i_dataX and i_validX until their readyX is seen. The block itself does not check this.
- Requester 1 i_data1 with i_valid1=0 never affects o_data, and likewise for requester 0.
- Behaviour is independent of N. Test at N=64 and N=8.

Test Plan:
- Reset: hold i_rst_n=0 for 2 cycles with both valids=1 and i_ready=1 -> o_ready0=o_ready1=0, o_valid=0, o_data=0, o_sel=0. The first cycle after release grants requester 0.
- Single requester: i_valid0=1, i_data0=0xA5 for one cycle, i_ready=1 -> o_ready0=1 in that cycle. Next cycle o_valid=1, o_data=0xA5, o_sel=0. The cycle after that o_valid=0.
- Contention with i_ready=1 continuously: both valid, i_data0=0x11, i_data1=0x22, held 4 cycles -> o_ready pattern 0,1,0,1; o_data 0x11,0x22,0x11,0x22 with no bubble; o_sel 0,1,0,1.
- Back-pressure: o_valid=1 with o_data=0x33, then i_ready=0 for 3 cycles with i_valid1=1 -> o_ready0=o_ready1=0 and o_data stays 0x33. On the cycle i_ready=1, o_ready1=1 and i_data1 appears on o_data the next cycle.
- Priority after uncontended grant: requester 1 alone transfers, then both valid -> requester 0 granted first (prio=0).
- Reset mid-stall: o_valid=1, i_ready=0, assert i_rst_n=0 for one edge -> o_valid=0, o_data=0. No ready was asserted during reset.

Source files
------------

// File: rtl/mux_2_rr_arbiter.sv
// Two-requester round-robin arbiter feeding one registered valid/ready output channel.
// The data path is a single 2:1 mux steered by the grant, followed by a 1-entry output register.

module mux_2 #(
  parameter int unsigned N = 64
) (
  input  logic [N-1:0] i_d0,
  input  logic [N-1:0] i_d1,
  input  logic         i_s,
  output logic [N-1:0] o_y
);

  assign o_y = i_s ? i_d1 : i_d0;

endmodule

module mux_2_rr_arbiter #(
  parameter int unsigned N = 64
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_data0,
  input  logic         i_valid0,
  output logic         o_ready0,
  input  logic [N-1:0] i_data1,
  input  logic         i_valid1,
  output logic         o_ready1,
  output logic [N-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         o_sel
);

  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_data_q, out_data_d;
  logic         out_sel_q, out_sel_d;
  logic         prio_q, prio_d;

  logic         can_accept;
  logic         grant;
  logic         accept;
  logic [N-1:0] mux_data;

  // The register can take a new word when empty or when its current word leaves this cycle.
  assign can_accept = !out_valid_q || i_ready;

  always_comb begin
    grant = 1'b0;
    unique case ({i_valid1, i_valid0})
      2'b11:   grant = prio_q;
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      default: grant = 1'b0;
    endcase
  end

  assign o_ready0 = i_rst_n && can_accept && i_valid0 && !grant;
  assign o_ready1 = i_rst_n && can_accept && i_valid1 && grant;
  assign accept   = o_ready0 || o_ready1;

  mux_2 #(
    .N (N)
  ) u_mux (
    .i_d0 (i_data0),
    .i_d1 (i_data1),
    .i_s  (grant),
    .o_y  (mux_data)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    prio_d      = prio_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_sel_d   = grant;
      // Toggling on every accept, contended or not, gives strict alternation under load.
      prio_d      = ~grant;
    end else if (out_valid_q && i_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 1'b0;
      prio_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      prio_q      <= prio_d;
    end
  end

  assign o_valid = out_valid_q;
  assign o_data  = out_data_q;
  assign o_sel   = out_sel_q;

`ifndef SYNTHESIS
  a_one_ready: assert property (@(posedge i_clk) !(o_ready0 && o_ready1));
  a_stall_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (out_valid_q && !i_ready) |=> (out_valid_q && $stable(out_data_q) && $stable(out_sel_q)));
`endif

endmodule

// File: tb/tb_mux_2_rr_arbiter.sv
// Directed bench for mux_2_rr_arbiter at N=64 and N=8 sharing one stimulus stream;
// expected output words go into a queue that a negedge monitor drains on each consumed word.

module tb_mux_2_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] d0, d1;
  logic        v0, v1, rdy;

  logic [63:0] od64;
  logic [7:0]  od8;
  logic        r0_64, r1_64, ov64, os64;
  logic        r0_8, r1_8, ov8, os8;

  int total = 0;
  int bad   = 0;
  logic [64:0] exp_q[$];

  always #5 clk = ~clk;

  mux_2_rr_arbiter #(.N(64)) dut64 (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_data0  (d0),
    .i_valid0 (v0),
    .o_ready0 (r0_64),
    .i_data1  (d1),
    .i_valid1 (v1),
    .o_ready1 (r1_64),
    .o_data   (od64),
    .o_valid  (ov64),
    .i_ready  (rdy),
    .o_sel    (os64)
  );

  mux_2_rr_arbiter #(.N(8)) dut8 (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_data0  (d0[7:0]),
    .i_valid0 (v0),
    .o_ready0 (r0_8),
    .i_data1  (d1[7:0]),
    .i_valid1 (v1),
    .o_ready1 (r1_8),
    .o_data   (od8),
    .o_valid  (ov8),
    .i_ready  (rdy),
    .o_sel    (os8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check readies mid-cycle, return just after the next rising edge.
  task automatic cyc(input logic rst, input logic iv0, input logic [63:0] id0,
                     input logic iv1, input logic [63:0] id1, input logic irdy,
                     input logic er0, input logic er1, input logic push);
    rst_n = rst; v0 = iv0; d0 = id0; v1 = iv1; d1 = id1; rdy = irdy;
    if (push && er0) exp_q.push_back({1'b0, id0});
    if (push && er1) exp_q.push_back({1'b1, id1});
    @(negedge clk);
    chk("ready0_n64", 64'(r0_64), 64'(er0));
    chk("ready1_n64", 64'(r1_64), 64'(er1));
    chk("ready0_n8", 64'(r0_8), 64'(er0));
    chk("ready1_n8", 64'(r1_8), 64'(er1));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic ev, input logic [63:0] ed,
                         input logic es);
    chk({name, "_valid_n64"}, 64'(ov64), 64'(ev));
    chk({name, "_valid_n8"}, 64'(ov8), 64'(ev));
    chk({name, "_data_n64"}, od64, ed);
    chk({name, "_data_n8"}, 64'(od8), {56'd0, ed[7:0]});
    chk({name, "_sel_n64"}, 64'(os64), 64'(es));
    chk({name, "_sel_n8"}, 64'(os8), 64'(es));
  endtask

  // Monitor: a word leaves at the next edge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (ov64 === 1'b1 && rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got %0h expected none", od64);
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        chk("mon_data_n64", od64, e[63:0]);
        chk("mon_sel_n64", 64'(os64), 64'(e[64]));
        chk("mon_valid_n8", 64'(ov8), 64'd1);
        chk("mon_data_n8", 64'(od8), {56'd0, e[7:0]});
        chk("mon_sel_n8", 64'(os8), 64'(e[64]));
      end
    end
  end

  logic [63:0] cont_exp [4];

  initial begin
    cont_exp[0] = 64'h11; cont_exp[1] = 64'h22; cont_exp[2] = 64'h11; cont_exp[3] = 64'h22;

    // Reset with both requesters and the consumer active.
    cyc(1'b0, 1'b1, 64'h01, 1'b1, 64'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_out("reset1", 1'b0, 64'h0, 1'b0);
    cyc(1'b0, 1'b1, 64'h01, 1'b1, 64'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_out("reset2", 1'b0, 64'h0, 1'b0);

    // First grant after release goes to requester 0.
    cyc(1'b1, 1'b1, 64'h01, 1'b1, 64'h02, 1'b1, 1'b1, 1'b0, 1'b1);
    chk_out("first", 1'b1, 64'h01, 1'b0);
    cyc(1'b1, 1'b0, 64'h0, 1'b1, 64'h02, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("idle_valid", 64'(ov64), 64'd0);

    // Single requester 0.
    cyc(1'b1, 1'b1, 64'hA5, 1'b0, 64'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
    chk_out("single", 1'b1, 64'hA5, 1'b0);
    cyc(1'b1, 1'b0, 64'h0, 1'b0, 64'hEE, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("single_drain_valid", 64'(ov64), 64'd0);

    // Uncontended requester 1, then contention starts with requester 0.
    cyc(1'b1, 1'b0, 64'h0, 1'b1, 64'h44, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b1, 64'h11, 1'b1, 64'h22, 1'b1, (k % 2) == 0, (k % 2) == 1, 1'b1);
      chk_out("contend", 1'b1, cont_exp[k], 1'((k % 2) == 1));
    end
    cyc(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("contend_drain_valid", 64'(ov64), 64'd0);

    // Back-pressure holds the word and blocks requester 1.
    cyc(1'b1, 1'b1, 64'h33, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 64'h0, 1'b1, 64'h55, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_out("stall", 1'b1, 64'h33, 1'b0);
    end
    cyc(1'b1, 1'b0, 64'h0, 1'b1, 64'h55, 1'b1, 1'b0, 1'b1, 1'b1);
    chk_out("unstall", 1'b1, 64'h55, 1'b1);
    cyc(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("unstall_drain_valid", 64'(ov64), 64'd0);

    // Reset during a stall discards the word and restores priority to requester 0.
    cyc(1'b1, 1'b1, 64'h66, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_out("held", 1'b1, 64'h66, 1'b0);
    cyc(1'b0, 1'b1, 64'h77, 1'b1, 64'h88, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_out("midreset", 1'b0, 64'h0, 1'b0);
    cyc(1'b1, 1'b1, 64'h77, 1'b1, 64'h88, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 64'h0, 1'b1, 64'h88, 1'b1, 1'b0, 1'b1, 1'b1);
    chk_out("post_reset", 1'b1, 64'h88, 1'b1);
    cyc(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("final_valid", 64'(ov64), 64'd0);
    chk("queue_left", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
